// File: rtl/adbg_tap_ctrl.sv
// IEEE 1149.1 TAP controller for the advanced debug interface: TAP FSM, IR, IDCODE/BYPASS DRs, TDO mux.
// Optional ADBG_TAP_TDO_NEGEDGE_EN registers tdo_o/tdo_oe_o on the falling edge of tck_i.
module adbg_tap_ctrl #(
  parameter int                IR_LEN       = 4,
  parameter logic [31:0]       IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_LEN-1:0] IDCODE_INSTR = IR_LEN'('h2),
  parameter logic [IR_LEN-1:0] DEBUG_INSTR  = IR_LEN'('h8),
  parameter logic [IR_LEN-1:0] BYPASS_INSTR = IR_LEN'('hF)
) (
  input  logic tck_i,
  input  logic trstn_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  output logic test_logic_reset_o,
  output logic run_test_idle_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic capture_dr_o,
  output logic debug_select_o,
  input  logic debug_tdo_i
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_t;

  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(1);

  tap_state_t        state_reg, state_next;
  logic [IR_LEN-1:0] ir_shift_reg;
  logic [IR_LEN-1:0] ir_reg;
  logic [31:0]       idcode_reg;
  logic              bypass_reg;
  logic              idcode_sel, debug_sel, bypass_sel;
  logic              tdo_next, tdo_oe_next;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      TLR:      state_next = tms_i ? TLR    : RTI;
      RTI:      state_next = tms_i ? SEL_DR : RTI;
      SEL_DR:   state_next = tms_i ? SEL_IR : CAP_DR;
      CAP_DR:   state_next = tms_i ? EX1_DR : SHIFT_DR;
      SHIFT_DR: state_next = tms_i ? EX1_DR : SHIFT_DR;
      EX1_DR:   state_next = tms_i ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_next = tms_i ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_next = tms_i ? UPD_DR : SHIFT_DR;
      UPD_DR:   state_next = tms_i ? SEL_DR : RTI;
      SEL_IR:   state_next = tms_i ? TLR    : CAP_IR;
      CAP_IR:   state_next = tms_i ? EX1_IR : SHIFT_IR;
      SHIFT_IR: state_next = tms_i ? EX1_IR : SHIFT_IR;
      EX1_IR:   state_next = tms_i ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_next = tms_i ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_next = tms_i ? UPD_IR : SHIFT_IR;
      UPD_IR:   state_next = tms_i ? SEL_DR : RTI;
    endcase
  end

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      state_reg <= TLR;
    end else begin
      state_reg <= state_next;
    end
  end

  // Entering Test-Logic-Reset clears the IR on that same edge, so debug_select_o drops with the state.
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      ir_shift_reg <= '0;
      ir_reg       <= IDCODE_INSTR;
    end else begin
      if (state_reg == CAP_IR) begin
        ir_shift_reg <= IR_CAPTURE;
      end else if (state_reg == SHIFT_IR) begin
        ir_shift_reg <= {tdi_i, ir_shift_reg[IR_LEN-1:1]};
      end
      if (state_reg == TLR || state_next == TLR) begin
        ir_reg <= IDCODE_INSTR;
      end else if (state_reg == UPD_IR) begin
        ir_reg <= ir_shift_reg;
      end
    end
  end

  assign debug_sel  = (ir_reg == DEBUG_INSTR);
  assign idcode_sel = (ir_reg == IDCODE_INSTR);
  assign bypass_sel = (ir_reg == BYPASS_INSTR) || !(debug_sel || idcode_sel);

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      idcode_reg <= '0;
      bypass_reg <= 1'b0;
    end else if (state_reg == CAP_DR) begin
      if (idcode_sel) begin
        idcode_reg <= IDCODE_VALUE;
      end
      bypass_reg <= 1'b0;
    end else if (state_reg == SHIFT_DR) begin
      idcode_reg <= {tdi_i, idcode_reg[31:1]};
      bypass_reg <= tdi_i;
    end
  end

  always_comb begin
    tdo_next    = 1'b0;
    tdo_oe_next = 1'b0;
    if (state_reg == SHIFT_IR) begin
      tdo_next    = ir_shift_reg[0];
      tdo_oe_next = 1'b1;
    end else if (state_reg == SHIFT_DR) begin
      tdo_oe_next = 1'b1;
      if (debug_sel) begin
        tdo_next = debug_tdo_i;
      end else if (idcode_sel) begin
        tdo_next = idcode_reg[0];
      end else if (bypass_sel) begin
        tdo_next = bypass_reg;
      end
    end
  end

`ifdef ADBG_TAP_TDO_NEGEDGE_EN
  logic tdo_reg, tdo_oe_reg;

  always_ff @(negedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      tdo_reg    <= 1'b0;
      tdo_oe_reg <= 1'b0;
    end else begin
      tdo_reg    <= tdo_next;
      tdo_oe_reg <= tdo_oe_next;
    end
  end

  assign tdo_o    = tdo_reg;
  assign tdo_oe_o = tdo_oe_reg;
`else
  assign tdo_o    = tdo_next;
  assign tdo_oe_o = tdo_oe_next;
`endif

  assign test_logic_reset_o = (state_reg == TLR);
  assign run_test_idle_o    = (state_reg == RTI);
  assign shift_dr_o         = (state_reg == SHIFT_DR);
  assign pause_dr_o         = (state_reg == PAUSE_DR);
  assign update_dr_o        = (state_reg == UPD_DR);
  assign capture_dr_o       = (state_reg == CAP_DR);
  assign debug_select_o     = debug_sel;

endmodule

// File: tb/tb_adbg_tap_ctrl.sv
// Self-checking bench for adbg_tap_ctrl: a vector table walks the TAP through IDCODE, BYPASS, DEBUG and
// TMS-reset scans; hand-written steps cover reset release and asynchronous reset mid-scan.
module tb_adbg_tap_ctrl;

  logic tck, trstn, tms, tdi, debug_tdo;
  logic tdo, tdo_oe, tlr, rti, sdr, pdr, udr, cdr, dsel;

  adbg_tap_ctrl u_dut (
    .tck_i              (tck),
    .trstn_i            (trstn),
    .tms_i              (tms),
    .tdi_i              (tdi),
    .tdo_o              (tdo),
    .tdo_oe_o           (tdo_oe),
    .test_logic_reset_o (tlr),
    .run_test_idle_o    (rti),
    .shift_dr_o         (sdr),
    .pause_dr_o         (pdr),
    .update_dr_o        (udr),
    .capture_dr_o       (cdr),
    .debug_select_o     (dsel),
    .debug_tdo_i        (debug_tdo)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // State-output bit groups: {tlr, rti, shift_dr, pause_dr, update_dr, capture_dr}
  localparam logic [5:0] S_TLR = 6'b100000;
  localparam logic [5:0] S_RTI = 6'b010000;
  localparam logic [5:0] S_SDR = 6'b001000;
  localparam logic [5:0] S_PDR = 6'b000100;
  localparam logic [5:0] S_UDR = 6'b000010;
  localparam logic [5:0] S_CDR = 6'b000001;
  localparam logic [5:0] S_NON = 6'b000000;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic       dbg;
    logic [5:0] st;
    logic       tdo;
    logic       oe;
    logic       sel;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [31:0] id_v;

  function automatic logic [8:0] observe();
    return {tlr, rti, sdr, pdr, udr, cdr, tdo, tdo_oe, dsel};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got st/tdo/oe/sel=%b required %b", name, got, want);
    end else begin
      $display("ok   %s: st/tdo/oe/sel=%b", name, got);
    end
  endtask

  task automatic add(input logic t_ms, input logic t_di, input logic t_dbg, input logic [5:0] st,
                     input logic e_tdo, input logic e_oe, input logic e_sel);
    vec_t v;
    v.tms = t_ms; v.tdi = t_di; v.dbg = t_dbg;
    v.st = st; v.tdo = e_tdo; v.oe = e_oe; v.sel = e_sel;
    vecs.push_back(v);
  endtask

  // Drive inputs while tck is low, let one rising edge pass, sample after the falling edge.
  task automatic step(input logic t_ms, input logic t_di, input logic t_dbg);
    tms = t_ms; tdi = t_di; debug_tdo = t_dbg;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  initial begin
    logic       t;
    logic [8:0] want;
    id_v = 32'h149511C3;

    // Test 2: IDCODE read, then bits fed in via TDI reappear after 32 shifts
    add(0, 0, 0, S_RTI, 0, 0, 0);
    add(1, 0, 0, S_NON, 0, 0, 0);
    add(0, 0, 0, S_CDR, 0, 0, 0);
    add(0, 0, 0, S_SDR, id_v[0], 1, 0);
    for (int k = 0; k < 35; k++) begin
      int m;
      m = k + 1;
      t = (k == 2 || k == 3);
      add(0, t, 0, S_SDR, (m < 32) ? id_v[m] : ((m - 32) == 2 || (m - 32) == 3), 1, 0);
    end
    add(1, 0, 0, S_NON, 0, 0, 0);
    add(1, 0, 0, S_UDR, 0, 0, 0);
    // Test 4: IR <= 5 (undefined opcode -> BYPASS), TDI 1,0,1,1 gives TDO 0,1,0,1
    add(1, 0, 0, S_NON, 0, 0, 0);
    add(1, 0, 0, S_NON, 0, 0, 0);
    add(0, 0, 0, S_NON, 0, 0, 0);
    add(0, 0, 0, S_NON, 1, 1, 0);
    add(0, 1, 0, S_NON, 0, 1, 0);
    add(0, 0, 0, S_NON, 0, 1, 0);
    add(0, 1, 0, S_NON, 0, 1, 0);
    add(1, 0, 0, S_NON, 0, 0, 0);
    add(1, 0, 0, S_NON, 0, 0, 0);
    add(0, 0, 0, S_RTI, 0, 0, 0);
    add(1, 0, 0, S_NON, 0, 0, 0);
    add(0, 0, 0, S_CDR, 0, 0, 0);
    add(0, 0, 0, S_SDR, 0, 1, 0);
    add(0, 1, 0, S_SDR, 1, 1, 0);
    add(0, 0, 0, S_SDR, 0, 1, 0);
    add(0, 1, 0, S_SDR, 1, 1, 0);
    add(1, 1, 0, S_NON, 0, 0, 0);
    add(1, 0, 0, S_UDR, 0, 0, 0);
    // Test 3: IR <= 8 (DEBUG), captured IR bits come out 1,0; tdo follows debug_tdo_i
    add(1, 0, 0, S_NON, 0, 0, 0);
    add(1, 0, 0, S_NON, 0, 0, 0);
    add(0, 0, 0, S_NON, 0, 0, 0);
    add(0, 0, 0, S_NON, 1, 1, 0);
    add(0, 0, 0, S_NON, 0, 1, 0);
    add(0, 0, 0, S_NON, 0, 1, 0);
    add(0, 0, 0, S_NON, 0, 1, 0);
    add(1, 1, 0, S_NON, 0, 0, 0);
    add(1, 0, 0, S_NON, 0, 0, 0);
    add(0, 0, 0, S_RTI, 0, 0, 1);
    add(1, 0, 0, S_NON, 0, 0, 1);
    add(0, 0, 0, S_CDR, 0, 0, 1);
    add(0, 0, 1, S_SDR, 1, 1, 1);
    add(0, 0, 0, S_SDR, 0, 1, 1);
    add(0, 0, 1, S_SDR, 1, 1, 1);
    add(0, 0, 0, S_SDR, 0, 1, 1);
    add(1, 0, 1, S_NON, 0, 0, 1);
    // Test 5: Pause-DR, then five TMS=1 edges reach Test-Logic-Reset and restore IDCODE
    add(0, 0, 0, S_PDR, 0, 0, 1);
    add(0, 0, 0, S_PDR, 0, 0, 1);
    add(1, 0, 0, S_NON, 0, 0, 1);
    add(1, 0, 0, S_UDR, 0, 0, 1);
    add(1, 0, 0, S_NON, 0, 0, 1);
    add(1, 0, 0, S_NON, 0, 0, 1);
    add(1, 0, 0, S_TLR, 0, 0, 0);
    add(0, 0, 0, S_RTI, 0, 0, 0);
    add(1, 0, 0, S_NON, 0, 0, 0);
    add(0, 0, 0, S_CDR, 0, 0, 0);
    add(0, 0, 0, S_SDR, id_v[0], 1, 0);
    for (int m = 1; m <= 6; m++) begin
      add(0, 0, 0, S_SDR, id_v[m], 1, 0);
    end

    // Test 1: reset held, then released; first edge with TMS=0 lands in Run-Test/Idle
    trstn = 1'b0; tms = 1'b1; tdi = 1'b0; debug_tdo = 1'b0;
    repeat (3) @(negedge tck);
    #1;
    check("reset_state", observe(), {S_TLR, 3'b000});
    trstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back({vecs[i].st, vecs[i].tdo, vecs[i].oe, vecs[i].sel});
      step(vecs[i].tms, vecs[i].tdi, vecs[i].dbg);
      want = exp_q.pop_front();
      check($sformatf("vec%0d", i), observe(), want);
    end

    // Test 6: asynchronous reset mid Shift-DR (tdo currently 1) with no tck edge
    trstn = 1'b0;
    #1;
    check("async_trst_mid_scan", observe(), {S_TLR, 3'b000});
    @(negedge tck);
    #1;
    check("trst_held", observe(), {S_TLR, 3'b000});
    trstn = 1'b1;
    step(0, 0, 0);
    check("after_trst_release", observe(), {S_RTI, 3'b000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adbg_tap_ctrl.md
Name: adbg_tap_ctrl

Overview:
IEEE 1149.1 TAP controller that sits in front of the advanced debug interface. It consumes the pin-level JTAG signals (TCK, TMS, TDI, TRSTn) and runs the 16-state TAP FSM and the instruction register. It generates the TAP-state strobes and the debug instruction select that the debug top level consumes, and it muxes TDO among IDCODE, BYPASS, IR and the debug chain.

Parameters:
IR_LEN, 4, instruction register width (min 2)
IDCODE_VALUE, 32'h149511C3, value shifted out by IDCODE; bit 0 must be 1
IDCODE_INSTR, 4'h2, IDCODE opcode
DEBUG_INSTR, 4'h8, opcode that asserts debug_select_o
BYPASS_INSTR, 4'hF, BYPASS opcode

Ports:
tck_i  in  1  JTAG clock; all state on posedge unless stated
trstn_i  in  1  asynchronous, active-low reset
tms_i  in  1  test mode select
tdi_i  in  1  test data in
tdo_o  out  1  test data out
tdo_oe_o  out  1  TDO output enable; high only while shifting
test_logic_reset_o  out  1  FSM in Test-Logic-Reset
run_test_idle_o  out  1  FSM in Run-Test/Idle
shift_dr_o  out  1  FSM in Shift-DR
pause_dr_o  out  1  FSM in Pause-DR
update_dr_o  out  1  FSM in Update-DR
capture_dr_o  out  1  FSM in Capture-DR
debug_select_o  out  1  latched IR == DEBUG_INSTR
debug_tdo_i  in  1  serial output of the debug chain

Behaviour:
- FSM: the 16 standard TAP states with the standard TMS transitions, registered on posedge tck_i.
- trstn_i low: state goes to Test-Logic-Reset asynchronously and latched IR goes to IDCODE_INSTR.
- From any state, 5 consecutive TMS=1 edges reach Test-Logic-Reset.
- In Test-Logic-Reset, latched IR is forced to IDCODE_INSTR on every edge.
- State outputs are pure decodes of the registered state; no combinational path from tms_i. The debug top therefore sees shift_dr_o during the same cycle in which it samples tdi_i.
- IR shift register:
  - Capture-IR: loads {(IR_LEN-2)'b0, 2'b01}.
  - Shift-IR: shifts right, tdi_i into MSB; LSB is the shift output.
  - Update-IR: copies into latched IR. Pause/Exit leave both registers unchanged.
- Instruction decode:
  - debug_select_o = (IR==DEBUG_INSTR).
  - IDCODE selected when IR==IDCODE_INSTR.
  - All other opcodes, BYPASS_INSTR included, select BYPASS.
- IDCODE DR (32 bits):
  - Capture-DR with IDCODE selected: loads IDCODE_VALUE.
  - Shift-DR: shifts right, tdi_i into bit 31.
  - More than 32 shifts returns the bits shifted in via TDI.
- BYPASS DR (1 bit): captures 0 in Capture-DR; in Shift-DR it loads tdi_i, giving a one-cycle delay.
- TDO mux:
  - Shift-IR: IR LSB.
  - Shift-DR: per instruction — debug_tdo_i / IDCODE LSB / BYPASS bit.
  - Otherwise: 0.
- tdo_oe_o: high iff state is Shift-IR or Shift-DR; it follows the same timing as tdo_o (see Optional Feature).
- Reset values:
  - test_logic_reset_o=1.
  - All other state outputs = 0.
  - debug_select_o = 0.
  - tdo_o = 0, tdo_oe_o = 0.
- IR changed mid-DR-scan: impossible by construction, since IR updates only in Update-IR.
- Reset mid-scan: all shift contents are discarded; there is no partial update.

Optional Feature:
ADBG_TAP_TDO_NEGEDGE_EN
- Defined: tdo_o and tdo_oe_o are flops clocked on negedge tck_i and asynchronously reset to 0 by trstn_i. Per IEEE 1149.1, they change half a cycle after the state change.
- Undefined: tdo_o and tdo_oe_o are combinational from state and the shift registers, for use when the board samples TDO on the posedge.

Test Plan:
1. Hold trstn_i=0, then release with tms_i=0 for 1 edge -> run_test_idle_o=1; all other state outputs 0; latched IR=4'h2.
2. From Run-Test/Idle, go to Shift-DR and shift 32 bits with tdi_i=0 -> TDO bits LSB-first equal 32'h149511C3, then 0s.
3. Shift-IR with IR 4'h8 (TDI LSB-first 0,0,0,1), then Update-IR -> first two TDO bits are 1,0; debug_select_o=1 after Update-IR; in Shift-DR, tdo_o tracks debug_tdo_i.
4. Load IR 4'h5 (undefined), then shift TDI pattern 1,0,1,1 in Shift-DR -> TDO 0,1,0,1 (bypass, one-bit delay).
5. From Pause-DR, drive 5 TMS=1 edges -> test_logic_reset_o=1; debug_select_o=0; IR=4'h2.
6. Assert trstn_i during Shift-DR -> state goes immediately to Test-Logic-Reset; shift_dr_o=0, tdo_oe_o=0, tdo_o=0 without a tck edge.
